// File: rtl/x_23k640_req_fifo_if.sv
// Request/head handshake bundle between the application, x_23k640_req_fifo and the 23K640 SPI engine.
// i_flush exists only when X_23K640_REQ_FIFO_FLUSH_EN is defined.
interface x_23k640_req_fifo_if;
  logic        i_valid;
  logic        o_accept;
  logic        i_rd_n_wr;
  logic [15:0] i_addr;
  logic [7:0]  i_wdata;
  logic        o_valid;
  logic        i_accept;
  logic        o_rd_n_wr;
  logic [15:0] o_addr;
  logic [7:0]  o_wdata;
  logic        i_rd_done;
  logic        o_full;
  logic        o_empty;
  logic [4:0]  o_rd_pend;
`ifdef X_23K640_REQ_FIFO_FLUSH_EN
  logic        i_flush;
`endif

  modport slave (
`ifdef X_23K640_REQ_FIFO_FLUSH_EN
    input  i_flush,
`endif
    input  i_valid, i_rd_n_wr, i_addr, i_wdata, i_accept, i_rd_done,
    output o_accept, o_valid, o_rd_n_wr, o_addr, o_wdata, o_full, o_empty, o_rd_pend
  );

  modport master (
`ifdef X_23K640_REQ_FIFO_FLUSH_EN
    output i_flush,
`endif
    output i_valid, i_rd_n_wr, i_addr, i_wdata, i_accept, i_rd_done,
    input  o_accept, o_valid, o_rd_n_wr, o_addr, o_wdata, o_full, o_empty, o_rd_pend
  );
endinterface

// File: rtl/x_23k640_req_fifo.sv
// Request queue feeding the 23K640 SPI engine; head held stable until accepted, pending reads tracked.
// Optional X_23K640_REQ_FIFO_FLUSH_EN adds a one-cycle flush input on the bus interface.
module x_23k640_req_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  x_23k640_req_fifo_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wp_reg;
  logic [AW-1:0] rp_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic [4:0]    rd_pend_reg;
  logic [4:0]    rd_pend_next;
  logic          full;
  logic          empty;
  logic          flush;
  logic          push;
  logic          pop;
  logic          pop_rd;
  logic          rd_dec;
  logic [24:0]   entry_arr [DEPTH];
  logic [24:0]   head;

`ifdef X_23K640_REQ_FIFO_FLUSH_EN
  assign flush = bus.i_flush;
`else
  assign flush = 1'b0;
`endif

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // No pass-through when full: a same-cycle pop does not free a slot for the push.
  assign push = bus.i_valid & ~full & ~i_rst & ~flush;
  assign pop  = ~empty & bus.i_accept & ~flush;

  assign head = entry_arr[rp_reg];

  assign bus.o_accept  = push;
  assign bus.o_valid   = ~empty;
  assign bus.o_full    = full;
  assign bus.o_empty   = empty;
  assign bus.o_rd_n_wr = head[24];
  assign bus.o_addr    = head[23:8];
  assign bus.o_wdata   = head[7:0];
  assign bus.o_rd_pend = rd_pend_reg;

  // Storage is reset so the head outputs are a defined zero before the first push.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [24:0] entry_reg;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        entry_reg <= '0;
      end else if (push && (wp_reg == AW'(gi))) begin
        entry_reg <= {bus.i_rd_n_wr, bus.i_addr, bus.i_wdata};
      end
    end
    assign entry_arr[gi] = entry_reg;
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else if (flush) begin
      rp_reg    <= wp_reg;
      count_reg <= '0;
    end else begin
      if (push) wp_reg <= wp_reg + AW'(1);
      if (pop)  rp_reg <= rp_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Outstanding-read counter: saturates at 31, completions at zero are ignored.
  assign pop_rd = pop & head[24];
  assign rd_dec = bus.i_rd_done & (rd_pend_reg != 5'd0);

  always_comb begin
    rd_pend_next = rd_pend_reg;
    if (pop_rd && !rd_dec) begin
      if (rd_pend_reg != 5'd31) rd_pend_next = rd_pend_reg + 5'd1;
    end else if (!pop_rd && rd_dec) begin
      rd_pend_next = rd_pend_reg - 5'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_pend_reg <= 5'd0;
    end else begin
      rd_pend_reg <= rd_pend_next;
    end
  end
endmodule

// File: tb/tb_x_23k640_req_fifo.sv
// Self-checking bench for x_23k640_req_fifo: vector table plus scoreboard model of the queue.
// Flush sequence is compiled only when X_23K640_REQ_FIFO_FLUSH_EN is defined.
module tb_x_23k640_req_fifo;
  localparam int DEPTH = 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  x_23k640_req_fifo_if bif ();

  x_23k640_req_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bif)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int exp_pend = 0;
  logic [24:0] sb [$];

  typedef struct packed {
    logic        v;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        acc;
    logic        e_acc;
    logic        e_val;
    logic        e_full;
    logic        e_empty;
    logic [15:0] e_head;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic v, input logic rd, input logic [15:0] a, input logic [7:0] d,
                       input logic acc, input logic done);
    bif.i_valid   = v;
    bif.i_rd_n_wr = rd;
    bif.i_addr    = a;
    bif.i_wdata   = d;
    bif.i_accept  = acc;
    bif.i_rd_done = done;
`ifdef X_23K640_REQ_FIFO_FLUSH_EN
    bif.i_flush   = 1'b0;
`endif
  endtask

  // Called at the negative edge: compare against the model, update it, advance to posedge+1.
  task automatic model_step();
    logic exp_acc;
    logic do_pop;
    logic pop_rd;
    logic dec;
    exp_acc = bif.i_valid && (sb.size() < DEPTH);
    chk("accept", bif.o_accept, exp_acc);
    chk("valid", bif.o_valid, sb.size() != 0);
    chk("full", bif.o_full, sb.size() == DEPTH);
    chk("empty", bif.o_empty, sb.size() == 0);
    chk("rd_pend", bif.o_rd_pend, exp_pend);
    if (sb.size() != 0) chk("head", {bif.o_rd_n_wr, bif.o_addr, bif.o_wdata}, sb[0]);
    do_pop = (sb.size() != 0) && bif.i_accept;
    pop_rd = do_pop && sb[0][24];
    if (do_pop) begin
      $display("pop  rd=%0b addr=%04h wdata=%02h", sb[0][24], sb[0][23:8], sb[0][7:0]);
      void'(sb.pop_front());
    end
    dec = bif.i_rd_done && (exp_pend != 0);
    if (pop_rd && !dec) exp_pend = (exp_pend == 31) ? 31 : exp_pend + 1;
    else if (!pop_rd && dec) exp_pend = exp_pend - 1;
    if (exp_acc) begin
      $display("push rd=%0b addr=%04h wdata=%02h", bif.i_rd_n_wr, bif.i_addr, bif.i_wdata);
      sb.push_back({bif.i_rd_n_wr, bif.i_addr, bif.i_wdata});
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic rd, input logic [15:0] a, input logic [7:0] d,
                     input logic acc, input logic done);
    drive(v, rd, a, d, acc, done);
    @(negedge i_clk);
    model_step();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    drive(1'b1, 1'b0, 16'h5555, 8'h55, 1'b1, 1'b1);
    repeat (2) begin
      @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_accept", bif.o_accept, 1'b0);
      chk("rst_valid", bif.o_valid, 1'b0);
      chk("rst_empty", bif.o_empty, 1'b1);
      chk("rst_full", bif.o_full, 1'b0);
      chk("rst_pend", bif.o_rd_pend, 5'd0);
      chk("rst_head", {bif.o_rd_n_wr, bif.o_addr, bif.o_wdata}, 25'd0);
    end
    $display("reset");
    i_rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    sb.delete();
    exp_pend = 0;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // v, addr, wdata, acc | exp accept, valid, full, empty, head addr
    tbl[0] = '{1'b1, 16'h0010, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000};
    tbl[1] = '{1'b1, 16'h0011, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010};
    tbl[2] = '{1'b1, 16'h0012, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010};
    tbl[3] = '{1'b1, 16'h0013, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010};
    tbl[4] = '{1'b1, 16'h0014, 8'hA4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010};
    tbl[5] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010};
    tbl[6] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0011};
    tbl[7] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0012};
    tbl[8] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0013};
    tbl[9] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};

    do_reset();

    // Fill to full, refused fifth push, drain in order.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, 1'b0, tbl[i].addr, tbl[i].wd, tbl[i].acc, 1'b0);
      @(negedge i_clk);
      chk("tbl_accept", bif.o_accept, tbl[i].e_acc);
      chk("tbl_valid", bif.o_valid, tbl[i].e_val);
      chk("tbl_full", bif.o_full, tbl[i].e_full);
      chk("tbl_empty", bif.o_empty, tbl[i].e_empty);
      if (tbl[i].e_val) chk("tbl_head", bif.o_addr, tbl[i].e_head);
      model_step();
    end

    // Head held while the engine stalls.
    cyc(1'b1, 1'b1, 16'h1FFF, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      @(negedge i_clk);
      if (i % 50 == 0) begin
        chk("hold_addr", bif.o_addr, 16'h1FFF);
        chk("hold_rd", bif.o_rd_n_wr, 1'b1);
      end
      model_step();
    end
    cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);

    // Simultaneous push/pop at count 2 across several pointer wraps.
    do_reset();
    cyc(1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 16'h0101, 8'h01, 1'b0, 1'b0);
    for (int i = 2; i < 14; i++) begin
      cyc(1'b1, 1'b0, 16'h0100 + 16'(i), 8'(i), 1'b1, 1'b0);
      chk("pp_count2", sb.size(), 2);
    end
    repeat (3) cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

    // Read tracking: 3 reads popped, one completion, then write pop with completion.
    do_reset();
    cyc(1'b1, 1'b1, 16'h0200, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 16'h0201, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 16'h0202, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 16'h0203, 8'h77, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    chk("pend_3", bif.o_rd_pend, 5'd3);
    cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
    chk("pend_2", bif.o_rd_pend, 5'd2);
    cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
    chk("pend_1", bif.o_rd_pend, 5'd1);
    chk("pend_empty", bif.o_empty, 1'b1);

`ifdef X_23K640_REQ_FIFO_FLUSH_EN
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0300 + 16'(i), 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h03FF, 8'hFF, 1'b0, 1'b0);
    bif.i_flush = 1'b1;
    @(negedge i_clk);
    chk("flush_accept", bif.o_accept, 1'b0);
    @(posedge i_clk);
    #1;
    $display("flush");
    sb.delete();
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    @(negedge i_clk);
    chk("flush_empty", bif.o_empty, 1'b1);
    chk("flush_pend", bif.o_rd_pend, 5'd1);
    model_step();
`endif

    // Reset in the middle of a burst discards queued entries.
    cyc(1'b1, 1'b1, 16'h0400, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 16'h0401, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 16'h0402, 8'h22, 1'b0, 1'b0);
    do_reset();

    // Pending-read saturation at 31 and release by a completion.
    for (int i = 0; i < 34; i++) cyc(1'b1, 1'b1, 16'h0500 + 16'(i), 8'h00, 1'b1, 1'b0);
    chk("pend_sat", bif.o_rd_pend, 5'd31);
    cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
    chk("pend_30", bif.o_rd_pend, 5'd30);
    cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
